servo_ramp: RTL and testbench
=============================

# servo_ramp

Slew-rate limiter that sits directly upstream of the servo pulse generator and drives its 8-bit `duty` input. It accepts a target position and step size over a valid/ready handshake, then moves `duty` toward the target by at most one step per servo frame. `duty` changes only on the falling edge of the generated servo pulse, so a pulse width never changes mid-pulse. The block prevents sudden full-scale jumps that brown out the supply or strip servo gears.

## Interface

- `MIN_DUTY`, default 8'd0: lowest `duty` ever driven; accepted targets are clamped up to it.
- `MAX_DUTY`, default 8'd255: highest `duty` ever driven; accepted targets are clamped down to it.
- `HOME_DUTY`, default 8'd128: `duty` value after reset. Must satisfy MIN_DUTY ≤ HOME_DUTY ≤ MAX_DUTY.
- `HOLD_FRAMES`, default 4: frames spent in HOLD after reaching the target, with no new target accepted; 0 skips HOLD.
- `clk` in 1: global clock.
- `rst` in 1: synchronous, active-high reset.
- `pdm_in` in 1: pulse output of the downstream servo generator, same clock domain.
- `tgt_valid` in 1: target offer.
- `tgt_ready` out 1: block can accept a target.
- `tgt_pos` in 8: requested position (duty units).
- `tgt_step` in 4: maximum change per frame; 0 means jump in one frame.
- `duty` out 8: duty value fed to the servo generator.
- `busy` out 1: high in MOVE or HOLD.
- `at_target` out 1: `duty` equals the latched target.

## Operation

- **Reset** (rst high at a clock edge):
  - state IDLE, `duty`=HOME_DUTY, latched target=HOME_DUTY, latched step=0.
  - `at_target`=1, `busy`=0, hold counter=0, `pdm_q`=0.
  - `tgt_ready` is 0 while rst is high.
- **Frame event `fe`** = `pdm_q` & ~`pdm_in`, where `pdm_q` is `pdm_in` registered. Only `fe` advances MOVE and HOLD.
- **Handshake:**
  - `tgt_ready` = (state==IDLE) & ~rst.
  - Transfer occurs when `tgt_valid` & `tgt_ready` are high at a clock edge.
  - On transfer: latch target = clamp(`tgt_pos`, MIN_DUTY, MAX_DUTY), latch `tgt_step`, go to MOVE.
  - If the clamped target equals `duty`, go to HOLD instead (or IDLE when HOLD_FRAMES=0).
- **States:**
  - IDLE: `duty` stays constant; `tgt_ready`=1.
  - MOVE: on each `fe`, let d = |target − duty| (9-bit unsigned).
    - If step=0 or d ≤ step: `duty` ← target, then go to HOLD (or IDLE when HOLD_FRAMES=0).
    - Otherwise `duty` ← `duty` ± step, computed in 9 bits; the result never passes the target and never leaves [MIN_DUTY, MAX_DUTY].
  - HOLD: counter loads HOLD_FRAMES−1 on entry and decrements on each `fe`. On the `fe` where the counter is 0, go to IDLE.
- `at_target` = (`duty` == target), registered alongside `duty`.
- **Reset mid-MOVE:** `duty` snaps to HOME_DUTY. This is the required behaviour, not a ramp.
- **`fe` coinciding with transfer:** impossible, because transfer only occurs in IDLE and IDLE ignores `fe`.
- **`tgt_valid` without ready:** the offer is held off; the upstream must keep `tgt_pos` stable until transfer.

## Timing

- Handshake latency: transfer at edge T gives `busy`=1 and `tgt_ready`=0 after edge T.
- `duty` update latency:
  - Let E be the first edge that samples `pdm_in`=0 after an edge that sampled it as 1.
  - `fe` is true between E and E+1.
  - `duty` updates at edge E+1, which is 2 edges after the pulse falls.
- One step per servo frame; at most one `duty` change per `fe`.
- All outputs are registered except `tgt_ready`, which is decoded from the state register and rst.
- Worst-case move time: ceil(|Δ|/step) frames, plus HOLD_FRAMES.

## Structure

- Package `servo_pkg` holds:
  - `DUTY_W`=8 and `STEP_W`=4.
  - State enum `ramp_state_t` {IDLE, MOVE, HOLD}.
  - The clamp function.
  - The same `DUTY_W` is used by the servo generator.
- Sub-module `servo_frame_det`: registers `pdm_in` and outputs the `fe` pulse.
- `servo_ramp` contains the FSM, step arithmetic, and hold counter.

## Test plan

- **Reset:** hold rst for 3 cycles → `duty`=128, `at_target`=1, `busy`=0, `tgt_ready`=0 during reset and 1 after.
- **Ramp up:** target 200, step 10, from 128 → `duty` sequence 138,148,…,198,200 across 8 frames. No change except 2 edges after each pulse falling edge. Then `busy` is held for 4 frames and `tgt_ready` returns high.
- **Ramp down with clamp:** MIN_DUTY=20, target 5, step 15, from 50 → `duty` 35,20; latched target is 20; `at_target` is set on the frame where `duty`=20.
- **Jump:** step 0, target 0 → `duty`=0 on the first frame event.
- **Busy rejection:** assert `tgt_valid` with target 50 during MOVE → `tgt_ready`=0 and no transfer. The held offer is accepted in the cycle after the return to IDLE.
- **Reset mid-MOVE:** apply reset while `duty`=160 during a ramp → `duty`=128 one edge later and state IDLE. HOLD_FRAMES=0 variant: `tgt_ready` returns in the cycle after the final step.

Source files
------------

// File: rtl/servo_pkg.sv
// servo_pkg: shared widths, ramp FSM states and target clamp for the servo path.
package servo_pkg;
  localparam int DUTY_W = 8;
  localparam int STEP_W = 4;
  typedef enum logic [1:0] {IDLE, MOVE, HOLD} ramp_state_t;
  function automatic logic [DUTY_W-1:0] clamp(input logic [DUTY_W-1:0] v, input logic [DUTY_W-1:0] lo,
                                               input logic [DUTY_W-1:0] hi);
    return v < lo ? lo : (v > hi ? hi : v);
  endfunction
endpackage

// File: rtl/servo_frame_det.sv
// servo_frame_det: one-cycle frame event on the falling edge of the servo pulse.
module servo_frame_det (
  input  logic clk,
  input  logic rst,
  input  logic pdm_in,
  output logic fe
);
  logic pdm_q, pdm_d, fe_q, fe_d;
  assign pdm_d = pdm_in;
  assign fe_d = pdm_q & ~pdm_in;
  assign fe = fe_q;
  // fe is registered so duty moves two edges after the pulse falls, well clear of the next pulse start
  always_ff @(posedge clk) begin
    if (rst) begin
      pdm_q <= 1'b0;
      fe_q <= 1'b0;
    end else begin
      pdm_q <= pdm_d;
      fe_q <= fe_d;
    end
  end
endmodule

// File: rtl/servo_ramp.sv
// servo_ramp: slew-rate limits duty toward an accepted target, one step per servo frame.
module servo_ramp
  import servo_pkg::*;
#(
  parameter logic [DUTY_W-1:0] MIN_DUTY = 8'd0,
  parameter logic [DUTY_W-1:0] MAX_DUTY = 8'd255,
  parameter logic [DUTY_W-1:0] HOME_DUTY = 8'd128,
  parameter int HOLD_FRAMES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pdm_in,
  input  logic              tgt_valid,
  output logic              tgt_ready,
  input  logic [DUTY_W-1:0] tgt_pos,
  input  logic [STEP_W-1:0] tgt_step,
  output logic [DUTY_W-1:0] duty,
  output logic              busy,
  output logic              at_target
);
  localparam ramp_state_t DONE_ST = HOLD_FRAMES == 0 ? IDLE : HOLD;
  localparam logic [15:0] HOLD_INIT = 16'(HOLD_FRAMES - 1);
  ramp_state_t state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d, tgt_q, tgt_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [15:0] hold_q, hold_d;
  logic at_target_q, at_target_d, busy_q, busy_d;
  logic fe, up;
  logic [DUTY_W:0] diff;
  servo_frame_det u_fd (.clk(clk), .rst(rst), .pdm_in(pdm_in), .fe(fe));
  assign tgt_ready = state_q == IDLE && !rst;
  assign up = tgt_q > duty_q;
  assign diff = up ? {1'b0, tgt_q} - {1'b0, duty_q} : {1'b0, duty_q} - {1'b0, tgt_q};
  assign duty = duty_q;
  assign busy = busy_q;
  assign at_target = at_target_q;
  always_comb begin
    state_d = state_q;
    duty_d = duty_q;
    tgt_d = tgt_q;
    step_d = step_q;
    hold_d = hold_q;
    case (state_q)
      IDLE: if (tgt_valid && tgt_ready) begin
        tgt_d = clamp(tgt_pos, MIN_DUTY, MAX_DUTY);
        step_d = tgt_step;
        state_d = tgt_d == duty_q ? DONE_ST : MOVE;
        hold_d = HOLD_INIT;
      end
      MOVE: if (fe) begin
        // a step never overshoots: the last partial step lands exactly on the target
        if (step_q == '0 || diff <= (DUTY_W+1)'(step_q)) begin
          duty_d = tgt_q;
          state_d = DONE_ST;
          hold_d = HOLD_INIT;
        end else begin
          duty_d = up ? duty_q + DUTY_W'(step_q) : duty_q - DUTY_W'(step_q);
        end
      end
      HOLD: if (fe) begin
        state_d = hold_q == '0 ? IDLE : HOLD;
        hold_d = hold_q - 16'd1;
      end
      default: state_d = IDLE;
    endcase
    at_target_d = duty_d == tgt_d;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      duty_q <= HOME_DUTY;
      tgt_q <= HOME_DUTY;
      step_q <= '0;
      hold_q <= '0;
      at_target_q <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q <= duty_d;
      tgt_q <= tgt_d;
      step_q <= step_d;
      hold_q <= hold_d;
      at_target_q <= at_target_d;
      busy_q <= busy_d;
    end
  end
endmodule

// File: tb/tb_servo_ramp.sv
// tb_servo_ramp: directed checks of servo_ramp in default, MIN_DUTY=20 and HOLD_FRAMES=0 builds.
module tb_servo_ramp;
  logic clk = 0, rst = 0, pdm_in = 0;
  logic [7:0] tgt_pos = 0;
  logic [3:0] tgt_step = 0;
  logic v0 = 0, v1 = 0, v2 = 0;
  logic r0, r1, r2, b0, b1, b2, a0, a1, a2;
  logic [7:0] duty0, duty1, duty2, duty_e;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  servo_ramp dut (.clk(clk), .rst(rst), .pdm_in(pdm_in), .tgt_valid(v0), .tgt_ready(r0), .tgt_pos(tgt_pos),
                  .tgt_step(tgt_step), .duty(duty0), .busy(b0), .at_target(a0));
  servo_ramp #(.MIN_DUTY(8'd20)) dut_c (.clk(clk), .rst(rst), .pdm_in(pdm_in), .tgt_valid(v1), .tgt_ready(r1),
                  .tgt_pos(tgt_pos), .tgt_step(tgt_step), .duty(duty1), .busy(b1), .at_target(a1));
  servo_ramp #(.HOLD_FRAMES(0)) dut_z (.clk(clk), .rst(rst), .pdm_in(pdm_in), .tgt_valid(v2), .tgt_ready(r2),
                  .tgt_pos(tgt_pos), .tgt_step(tgt_step), .duty(duty2), .busy(b2), .at_target(a2));

  // one servo pulse; returns at edge E+1 (+1) with duty0 as seen at edge E kept in duty_e
  task automatic frame();
    @(posedge clk); #1 pdm_in = 1;
    repeat (3) @(posedge clk);
    #1 pdm_in = 0;
    @(posedge clk); #1 duty_e = duty0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (r0 !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", r0); end
    checks++; if (duty0 !== 8'd128) begin errors++; $display("FAIL rst_duty: got %0d want 128", duty0); end
    checks++; if (a0 !== 1'b1) begin errors++; $display("FAIL rst_at_target: got %b want 1", a0); end
    checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", b0); end
    checks++; if (duty1 !== 8'd128 || duty2 !== 8'd128) begin errors++; $display("FAIL rst_duty_variants: got %0d/%0d want 128", duty1, duty2); end
    rst = 0; #1;
    checks++; if (r0 !== 1'b1 || r1 !== 1'b1 || r2 !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b%b%b want 111", r0, r1, r2); end
  endtask

  task automatic test_ramp_up();
    logic [7:0] prev, exp;
    tgt_pos = 200; tgt_step = 10; v0 = 1;
    @(posedge clk); #1 v0 = 0;
    checks++; if (b0 !== 1'b1 || r0 !== 1'b0) begin errors++; $display("FAIL up_handshake: busy=%b ready=%b want 1/0", b0, r0); end
    checks++; if (a0 !== 1'b0) begin errors++; $display("FAIL up_at_target0: got %b want 0", a0); end
    for (int i = 1; i <= 8; i++) begin
      prev = duty0;
      exp = i == 8 ? 8'd200 : 8'(128 + 10 * i);
      frame();
      checks++; if (duty_e !== prev) begin errors++; $display("FAIL up_early[%0d]: got %0d want %0d", i, duty_e, prev); end
      checks++; if (duty0 !== exp) begin errors++; $display("FAIL up_duty[%0d]: got %0d want %0d", i, duty0, exp); end
    end
    checks++; if (a0 !== 1'b1 || b0 !== 1'b1) begin errors++; $display("FAIL up_reached: at=%b busy=%b want 1/1", a0, b0); end
    repeat (3) frame();
    checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL up_hold3: busy=%b want 1", b0); end
    frame();
    checks++; if (b0 !== 1'b0 || r0 !== 1'b1) begin errors++; $display("FAIL up_hold_done: busy=%b ready=%b want 0/1", b0, r0); end
  endtask

  task automatic test_clamp();
    tgt_pos = 50; tgt_step = 0; v1 = 1;
    @(posedge clk); #1 v1 = 0;
    frame();
    checks++; if (duty1 !== 8'd50) begin errors++; $display("FAIL clamp_pre: got %0d want 50", duty1); end
    repeat (4) frame();
    tgt_pos = 5; tgt_step = 15; v1 = 1;
    @(posedge clk); #1 v1 = 0;
    checks++; if (a1 !== 1'b0 || b1 !== 1'b1) begin errors++; $display("FAIL clamp_start: at=%b busy=%b want 0/1", a1, b1); end
    frame();
    checks++; if (duty1 !== 8'd35 || a1 !== 1'b0) begin errors++; $display("FAIL clamp_f1: duty=%0d at=%b want 35/0", duty1, a1); end
    frame();
    checks++; if (duty1 !== 8'd20 || a1 !== 1'b1) begin errors++; $display("FAIL clamp_f2: duty=%0d at=%b want 20/1", duty1, a1); end
    repeat (4) frame();
    checks++; if (b1 !== 1'b0 || duty1 !== 8'd20) begin errors++; $display("FAIL clamp_idle: busy=%b duty=%0d want 0/20", b1, duty1); end
  endtask

  task automatic test_jump();
    tgt_pos = 0; tgt_step = 0; v0 = 1;
    @(posedge clk); #1 v0 = 0;
    frame();
    checks++; if (duty0 !== 8'd0 || a0 !== 1'b1) begin errors++; $display("FAIL jump: duty=%0d at=%b want 0/1", duty0, a0); end
    repeat (4) frame();
    checks++; if (r0 !== 1'b1) begin errors++; $display("FAIL jump_idle: ready=%b want 1", r0); end
  endtask

  task automatic test_busy_reject();
    tgt_pos = 100; tgt_step = 10; v0 = 1;
    @(posedge clk); #1 tgt_pos = 50;
    frame();
    checks++; if (r0 !== 1'b0 || duty0 !== 8'd10) begin errors++; $display("FAIL rej_move: ready=%b duty=%0d want 0/10", r0, duty0); end
    repeat (9) frame();
    checks++; if (duty0 !== 8'd100) begin errors++; $display("FAIL rej_reach: got %0d want 100", duty0); end
    repeat (3) frame();
    checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL rej_hold: busy=%b want 1", b0); end
    frame();
    checks++; if (r0 !== 1'b1) begin errors++; $display("FAIL rej_idle_ready: got %b want 1", r0); end
    @(posedge clk); #1 v0 = 0;
    checks++; if (b0 !== 1'b1 || r0 !== 1'b0) begin errors++; $display("FAIL rej_accept: busy=%b ready=%b want 1/0", b0, r0); end
    frame();
    checks++; if (duty0 !== 8'd90) begin errors++; $display("FAIL rej_down: got %0d want 90", duty0); end
    repeat (4) frame();
    checks++; if (duty0 !== 8'd50 || a0 !== 1'b1) begin errors++; $display("FAIL rej_final: duty=%0d at=%b want 50/1", duty0, a0); end
    repeat (4) frame();
  endtask

  task automatic test_reset_mid_move();
    tgt_pos = 200; tgt_step = 10; v0 = 1;
    @(posedge clk); #1 v0 = 0;
    repeat (11) frame();
    checks++; if (duty0 !== 8'd160 || b0 !== 1'b1) begin errors++; $display("FAIL mid_pre: duty=%0d busy=%b want 160/1", duty0, b0); end
    rst = 1;
    @(posedge clk); #1;
    checks++; if (duty0 !== 8'd128 || b0 !== 1'b0 || r0 !== 1'b0) begin errors++; $display("FAIL mid_rst: duty=%0d busy=%b ready=%b want 128/0/0", duty0, b0, r0); end
    rst = 0; #1;
    checks++; if (r0 !== 1'b1 || a0 !== 1'b1) begin errors++; $display("FAIL mid_idle: ready=%b at=%b want 1/1", r0, a0); end
    frame();
    checks++; if (duty0 !== 8'd128) begin errors++; $display("FAIL mid_still: got %0d want 128", duty0); end
  endtask

  task automatic test_hold0();
    tgt_pos = 140; tgt_step = 5; v2 = 1;
    @(posedge clk); #1 v2 = 0;
    frame();
    checks++; if (duty2 !== 8'd133 || r2 !== 1'b0) begin errors++; $display("FAIL h0_f1: duty=%0d ready=%b want 133/0", duty2, r2); end
    frame();
    checks++; if (duty2 !== 8'd138 || r2 !== 1'b0) begin errors++; $display("FAIL h0_f2: duty=%0d ready=%b want 138/0", duty2, r2); end
    frame();
    checks++; if (duty2 !== 8'd140 || r2 !== 1'b1 || b2 !== 1'b0 || a2 !== 1'b1) begin errors++; $display("FAIL h0_f3: duty=%0d ready=%b busy=%b at=%b want 140/1/0/1", duty2, r2, b2, a2); end
    v2 = 1;
    @(posedge clk); #1 v2 = 0;
    checks++; if (b2 !== 1'b0 || r2 !== 1'b1) begin errors++; $display("FAIL h0_same: busy=%b ready=%b want 0/1", b2, r2); end
    tgt_pos = 128; v0 = 1;
    @(posedge clk); #1 v0 = 0;
    checks++; if (b0 !== 1'b1 || r0 !== 1'b0) begin errors++; $display("FAIL same_hold: busy=%b ready=%b want 1/0", b0, r0); end
    repeat (4) frame();
    checks++; if (r0 !== 1'b1 || duty0 !== 8'd128) begin errors++; $display("FAIL same_done: ready=%b duty=%0d want 1/128", r0, duty0); end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_clamp();
    test_jump();
    test_busy_reject();
    test_reset_mid_move();
    test_hold0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
